// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control unit: FSM states,
// opcodes and datapath mux/ALU select values.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    // Opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Immediate extender formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_U = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_S = 3'b100;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Coarse ALU request from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Loads and stores share the address-calculation path
    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OP_LOAD) || (opcode == OP_STORE);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus funct fields to an ALU operation.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // Select the ALU operation; sub only for R-type (op5) with funct7b5
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        if (op5 && funct7b5) begin
                            alu_control = ALU_SUB;
                        end else begin
                            alu_control = ALU_ADD;
                        end
                    end
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM. Outputs are decoded from the state register
// (with mem_ready/zero qualifying a few enables); enables are forced low
// while reset is asserted.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter bit STRICT_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [2:0] alu_control,
    output logic       reg_write,
    output logic       illegal,
    output logic       instr_done
);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] w_alu_op;

    alu_decoder u_alu_decoder (
        .alu_op      (w_alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

    // State register: the only storage in the control unit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and output decode; every output defaults to 0
    always_comb begin
        w_next_state = r_state;
        w_alu_op     = ALUOP_ADD;
        pc_write     = 1'b0;
        adr_src      = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        result_src   = RES_ALUOUT;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_REGB;
        imm_src      = IMM_I;
        reg_write    = 1'b0;
        illegal      = 1'b0;
        instr_done   = 1'b0;

        case (r_state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
                if (is_mem_op(op)) begin
                    w_next_state = S_MEMADR;
                end else begin
                    case (op)
                        OP_RTYPE:  w_next_state = S_EXECR;
                        OP_ITYPE:  w_next_state = S_EXECI;
                        OP_BRANCH: w_next_state = S_BRANCH;
                        OP_JAL:    w_next_state = S_JAL;
                        OP_LUI:    w_next_state = S_LUI;
                        default:   w_next_state = STRICT_ILLEGAL ? S_TRAP : S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_IMM;
                if (op == OP_STORE) begin
                    imm_src      = IMM_S;
                    w_next_state = S_MEMWRITE;
                end else begin
                    imm_src      = IMM_I;
                    w_next_state = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) begin
                    w_next_state = S_MEMWB;
                end else begin
                    w_next_state = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                result_src   = RES_DATA;
                reg_write    = 1'b1;
                instr_done   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                // Write strobe held for the whole wait
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    instr_done   = 1'b1;
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_MEMWRITE;
                end
            end
            S_EXECR: begin
                alu_src_a    = SRCA_REGA;
                alu_src_b    = SRCB_REGB;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a    = SRCA_REGA;
                alu_src_b    = SRCB_IMM;
                imm_src      = IMM_I;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                result_src   = RES_ALUOUT;
                reg_write    = 1'b1;
                instr_done   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                // funct3[0] inverts the sense: beq takes on zero, bne on !zero
                alu_src_a    = SRCA_REGA;
                alu_src_b    = SRCB_REGB;
                w_alu_op     = ALUOP_SUB;
                result_src   = RES_ALUOUT;
                pc_write     = zero ^ funct3[0];
                instr_done   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALUOUT;
                imm_src      = IMM_J;
                pc_write     = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_LUI: begin
                imm_src      = IMM_U;
                result_src   = RES_IMM;
                reg_write    = 1'b1;
                instr_done   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_TRAP: begin
                illegal      = 1'b1;
                w_next_state = S_TRAP;
            end
            default: begin
                w_next_state = STRICT_ILLEGAL ? S_TRAP : S_FETCH;
            end
        endcase

        // Keep every enable quiet while reset is held
        if (!rst_n) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            illegal    = 1'b0;
            instr_done = 1'b0;
        end else begin
            w_next_state = w_next_state;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a strict and a lax instance run
// side by side; all outputs are packed into one vector and compared
// against hand-written per-state expectations each cycle.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       pcw_s, adr_s, mw_s, irw_s, rw_s, ill_s, done_s;
    logic [1:0] rs_s, sa_s, sb_s;
    logic [2:0] imm_s, alu_s;
    logic       pcw_l, adr_l, mw_l, irw_l, rw_l, ill_l, done_l;
    logic [1:0] rs_l, sa_l, sb_l;
    logic [2:0] imm_l, alu_l;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.STRICT_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(pcw_s), .adr_src(adr_s), .mem_write(mw_s), .ir_write(irw_s),
        .result_src(rs_s), .alu_src_a(sa_s), .alu_src_b(sb_s), .imm_src(imm_s),
        .alu_control(alu_s), .reg_write(rw_s), .illegal(ill_s), .instr_done(done_s)
    );

    multicycle_ctrl #(.STRICT_ILLEGAL(1'b0)) dut_lax (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(pcw_l), .adr_src(adr_l), .mem_write(mw_l), .ir_write(irw_l),
        .result_src(rs_l), .alu_src_a(sa_l), .alu_src_b(sb_l), .imm_src(imm_l),
        .alu_control(alu_l), .reg_write(rw_l), .illegal(ill_l), .instr_done(done_l)
    );

    wire [18:0] obs_s = {pcw_s, adr_s, mw_s, irw_s, rs_s, sa_s, sb_s, imm_s, alu_s, rw_s, ill_s, done_s};
    wire [18:0] obs_l = {pcw_l, adr_l, mw_l, irw_l, rs_l, sa_l, sb_l, imm_l, alu_l, rw_l, ill_l, done_l};

    // Field order: pcw adr mw irw result_src src_a src_b imm alu rw ill done
    function automatic logic [18:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] imm, input logic [2:0] alu,
                                       input logic rw, input logic ill, input logic done);
        return {pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, ill, done};
    endfunction

    function automatic logic [18:0] v_fetch();
        return mk(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [18:0] v_fetch_idle();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [18:0] v_decode();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [18:0] v_aluwb();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1);
    endfunction
    function automatic logic [18:0] v_trap();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_both(input string tag, input logic [18:0] expected);
        check({tag, " strict"}, {13'd0, obs_s}, {13'd0, expected});
        check({tag, " lax"},    {13'd0, obs_l}, {13'd0, expected});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Applies an instruction and checks the FETCH and DECODE cycles
    task automatic fetch_decode(input logic [6:0] o, input logic [2:0] f3, input logic f7, input string tag);
        op = o; funct3 = f3; funct7b5 = f7; mem_ready = 1'b1;
        #1;
        check_both({tag, " fetch"}, v_fetch());
        tick();
        check_both({tag, " decode"}, v_decode());
    endtask

    logic [2:0] f3_tab  [5] = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b100};
    logic [2:0] alu_tab [5] = '{3'b000, 3'b101, 3'b011, 3'b010, 3'b000};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        #1;
        check_both("reset", v_fetch_idle());

        // Leave reset between edges with memory not ready: FETCH must wait
        mem_ready = 1'b0;
        #12;
        rst_n = 1'b1;
        #1;
        check_both("fetch wait0", v_fetch_idle());
        tick();
        check_both("fetch wait1", v_fetch_idle());

        // lw
        fetch_decode(7'b0000011, 3'b010, 1'b0, "lw");
        tick();
        check_both("lw memadr", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
        tick();
        check_both("lw memread", mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
        tick();
        check_both("lw memwb", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1));
        tick();

        // beq taken, bne not taken, bne taken
        zero = 1'b1;
        fetch_decode(7'b1100011, 3'b000, 1'b0, "beq");
        tick();
        check_both("beq branch", mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1));
        tick();
        fetch_decode(7'b1100011, 3'b001, 1'b0, "bne z1");
        tick();
        check_both("bne z1 branch", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1));
        tick();
        zero = 1'b0;
        fetch_decode(7'b1100011, 3'b001, 1'b0, "bne z0");
        tick();
        check_both("bne z0 branch", mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1));
        tick();

        // sw with three stalled cycles
        fetch_decode(7'b0100011, 3'b010, 1'b0, "sw");
        mem_ready = 1'b0;
        tick();
        check_both("sw memadr", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check_both($sformatf("sw stall%0d", i), mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
        end
        mem_ready = 1'b1;
        #1;
        check_both("sw ready", mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1));
        tick();
        check_both("sw back fetch", v_fetch());

        // R-type sub
        fetch_decode(7'b0110011, 3'b000, 1'b1, "sub");
        tick();
        check_both("sub execr", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0));
        tick();
        check_both("sub aluwb", v_aluwb());
        tick();

        // I-type ALU ops, including funct7b5=1 on addi which must stay add
        for (int i = 0; i < 5; i++) begin
            fetch_decode(7'b0010011, f3_tab[i], 1'b1, $sformatf("itype%0d", i));
            tick();
            check_both($sformatf("itype%0d execi", i),
                       mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, alu_tab[i], 1'b0, 1'b0, 1'b0));
            tick();
            check_both($sformatf("itype%0d aluwb", i), v_aluwb());
            tick();
        end

        // jal
        fetch_decode(7'b1101111, 3'b000, 1'b0, "jal");
        tick();
        check_both("jal jal", mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b011, 3'b000, 1'b0, 1'b0, 1'b0));
        tick();
        check_both("jal aluwb", v_aluwb());
        tick();

        // lui
        fetch_decode(7'b0110111, 3'b000, 1'b0, "lui");
        tick();
        check_both("lui lui", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 3'b001, 3'b000, 1'b1, 1'b0, 1'b1));
        tick();

        // Reset in the middle of a store wait must drop mem_write at once
        fetch_decode(7'b0100011, 3'b010, 1'b0, "sw rst");
        mem_ready = 1'b0;
        tick();
        tick();
        check_both("sw rst stall", mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b0;
        #1;
        check_both("sw rst async", v_fetch_idle());
        tick();
        rst_n = 1'b1;
        #1;

        // Illegal opcode: strict traps, lax returns to FETCH
        fetch_decode(7'b1111111, 3'b000, 1'b0, "ill");
        tick();
        check("ill strict trap", {13'd0, obs_s}, {13'd0, v_trap()});
        check("ill lax fetch", {13'd0, obs_l}, {13'd0, v_fetch()});
        tick();
        check("ill strict hold", {13'd0, obs_s}, {13'd0, v_trap()});
        check("ill lax decode", {13'd0, obs_l}, {13'd0, v_decode()});
        mem_ready = 1'b0;
        tick();
        check("ill strict hold2", {13'd0, obs_s}, {13'd0, v_trap()});
        #2;
        rst_n = 1'b0;
        #1;
        check("ill rst illegal", {31'd0, ill_s}, 32'd0);
        check_both("ill rst async", v_fetch_idle());
        tick();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_both("post rst fetch", v_fetch());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter STRICT_ILLEGAL, default 1: 1 = an unsupported opcode enters TRAP; 0 = it is treated as NOP and returns to FETCH.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-004 SHALL have port op, input, 7 bits: opcode from the instruction register, bits [6:0].
REQ-005 SHALL have port funct3, input, 3 bits: instruction bits [14:12].
REQ-006 SHALL have port funct7b5, input, 1 bit: instruction bit 30.
REQ-007 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-008 SHALL have port mem_ready, input, 1 bit: memory access completes in the current cycle.
REQ-009 SHALL have output pc_write, 1 bit: PC load enable, covering unconditional PC update and a taken branch.
REQ-010 SHALL have output adr_src, 1 bit: memory address select (0 = PC, 1 = ALUOut).
REQ-011 SHALL have output mem_write, 1 bit: memory write enable.
REQ-012 SHALL have output ir_write, 1 bit: instruction register and OldPC load enable.
REQ-013 SHALL have output result_src, 2 bits: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
REQ-014 SHALL have output alu_src_a, 2 bits: 00 = PC, 01 = OldPC, 10 = RegA.
REQ-015 SHALL have output alu_src_b, 2 bits: 00 = RegB, 01 = ImmExt, 10 = constant 4.
REQ-016 SHALL have output imm_src, 3 bits, for the immediate extender: 000 = I, 001 = U, 010 = B, 011 = J, 100 = S.
REQ-017 SHALL have output alu_control, 3 bits: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
REQ-018 SHALL have outputs reg_write (1 bit), illegal (1 bit), and instr_done (1-cycle pulse marking the final state of each instruction).

Function
REQ-019 SHALL implement the Moore FSM states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI and TRAP.
REQ-020 In FETCH, the block SHALL drive adr_src=0, alu_src_a=00, alu_src_b=10, add and result_src=10, and assert ir_write and pc_write only when mem_ready=1; with mem_ready=0 it SHALL stay in FETCH with both deasserted.
REQ-021 In DECODE, the block SHALL drive alu_src_a=01, alu_src_b=01, add and imm_src=010 (branch target precompute), then branch on op.
REQ-022 From DECODE the next state SHALL be:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BRANCH
- 1101111 -> JAL
- 0110111 -> LUI
- any other opcode -> TRAP when STRICT_ILLEGAL=1, else FETCH.
REQ-023 In MEMADR, the block SHALL drive alu_src_a=10, alu_src_b=01, add, and imm_src=000 for loads or 100 for stores; next state is MEMREAD for loads, MEMWRITE for stores.
REQ-024 MEMREAD (adr_src=1) and MEMWRITE (adr_src=1, mem_write=1) SHALL hold until mem_ready=1; MEMREAD then moves to MEMWB, MEMWRITE to FETCH; mem_write SHALL stay asserted throughout the wait.
REQ-025 MEMWB SHALL drive result_src=01 and reg_write=1, then FETCH.
REQ-026 EXECR/EXECI SHALL drive alu_src_a=10, with alu_src_b=00 for EXECR or alu_src_b=01, imm_src=000 for EXECI, then go to ALUWB (result_src=00, reg_write=1), then FETCH.
REQ-027 ALU decode for R and I types SHALL follow funct3:
- 000 -> add, or sub when op[5]&funct7b5 (R-type only)
- 010 -> slt
- 110 -> or
- 111 -> and
- other funct3 -> add.
REQ-028 BRANCH SHALL drive alu_src_a=10, alu_src_b=00, sub and result_src=00, with pc_write = zero XOR funct3[0] (beq/bne), then FETCH.
REQ-029 JAL SHALL drive alu_src_a=01, alu_src_b=10, add, result_src=00, imm_src=011 and pc_write=1, then ALUWB.
REQ-030 LUI SHALL drive imm_src=001, result_src=11 and reg_write=1, then FETCH.
REQ-031 TRAP SHALL assert illegal and hold all enables low indefinitely until reset.
REQ-032 instr_done SHALL pulse in MEMWB, MEMWRITE (on the mem_ready=1 cycle), ALUWB, BRANCH and LUI.
REQ-033 In any state, outputs not listed for that state SHALL be 0.

Reset
REQ-034 On rst_n=0, the state SHALL go to FETCH asynchronously and all enables (pc_write, ir_write, mem_write, reg_write, illegal, instr_done) SHALL be 0, including during MEMWRITE waits.
REQ-035 After rst_n deasserts, the first fetch SHALL occur at the first rising clk edge with mem_ready=1.

Structure
REQ-036 Package rv_ctrl_pkg SHALL hold the state enum, opcode constants, the imm_src, alu_control, result_src and alu_src encodings.
REQ-037 ALU decode SHALL be a sub-module named alu_decoder (inputs alu_op[1:0], funct3, op5, funct7b5); the FSM register is the only sequential logic.

Verification
REQ-038 Scenario lw: op=0000011, mem_ready=1 -> FETCH, DECODE, MEMADR (imm_src=000), MEMREAD, MEMWB (result_src=01, reg_write=1); 5 cycles, one instr_done.
REQ-039 Scenario beq: op=1100011, funct3=000, zero=1 -> pc_write=1 in BRANCH; bne funct3=001, zero=1 -> pc_write=0.
REQ-040 Scenario sw stall: op=0100011, mem_ready=0 for 3 cycles in MEMWRITE -> mem_write held 1 for 4 cycles, instr_done only on the ready cycle.
REQ-041 Scenario R-type sub: op=0110011, funct3=000, funct7b5=1 -> alu_control=001 in EXECR; the I-type equivalent with funct7b5=1 -> 000.
REQ-042 Scenario illegal: op=1111111 with STRICT_ILLEGAL=1 -> TRAP, illegal=1; with STRICT_ILLEGAL=0 -> FETCH after DECODE; rst_n=0 mid-trap -> FETCH, illegal=0 immediately.
